// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl -- three-channel LED level slewer with a MANUAL / AUTO colour wheel.
//
// Every STEP_CYCLES clocks a tick moves each level one step toward its effective
// target. In MANUAL the targets come from target0..2. In AUTO they come from a
// six-entry colour-wheel table indexed by phase. The phase advances once every
// level has settled on its table entry.
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous, active-high reset
//   target0..2        MANUAL-mode targets (LEVEL_WIDTH each)
//   mode_btn          debounced button level; each rising edge toggles mode
//   level0..2         registered PWM levels (LEVEL_WIDTH each)
//   mode              registered mode: 0 MANUAL, 1 AUTO
//   phase             registered AUTO colour-wheel phase, 0..5
//   busy              1 while any level differs from its effective target
module rgb_fade_ctrl #(
    parameter int unsigned LEVEL_WIDTH = 8,
    parameter int unsigned STEP_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEVEL_WIDTH-1:0] target0,
    input  logic [LEVEL_WIDTH-1:0] target1,
    input  logic [LEVEL_WIDTH-1:0] target2,
    input  logic                   mode_btn,
    output logic [LEVEL_WIDTH-1:0] level0,
    output logic [LEVEL_WIDTH-1:0] level1,
    output logic [LEVEL_WIDTH-1:0] level2,
    output logic                   mode,
    output logic [2:0]             phase,
    output logic                   busy
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_e;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   btn_q, btn_d;
    mode_e                  mode_q, mode_d;
    logic [2:0]             phase_q, phase_d;
    logic [LEVEL_WIDTH-1:0] lvl_q [3];
    logic [LEVEL_WIDTH-1:0] lvl_d [3];
    logic [LEVEL_WIDTH-1:0] tgt   [3];
    logic                   tick;
    logic                   btn_rise;
    logic                   all_eq;

    // One step toward the target; never overshoots and never wraps.
    function automatic logic [LEVEL_WIDTH-1:0] slew(input logic [LEVEL_WIDTH-1:0] lvl,
                                                    input logic [LEVEL_WIDTH-1:0] tg);
        if (lvl < tg) begin
            return lvl + 1'b1;
        end else if (lvl > tg) begin
            return lvl - 1'b1;
        end
        return lvl;
    endfunction

    // Effective targets: inputs in MANUAL, colour-wheel table in AUTO.
    always_comb begin
        tgt[0] = target0;
        tgt[1] = target1;
        tgt[2] = target2;
        if (mode_q == AUTO) begin
            tgt[0] = (phase_q == 3'd0 || phase_q == 3'd4 || phase_q == 3'd5) ? '1 : '0;
            tgt[1] = (phase_q == 3'd0 || phase_q == 3'd1 || phase_q == 3'd2) ? '1 : '0;
            tgt[2] = (phase_q == 3'd2 || phase_q == 3'd3 || phase_q == 3'd4) ? '1 : '0;
        end
    end

    assign tick     = (cnt_q == CNT_LAST);
    assign btn_rise = mode_btn & ~btn_q;
    assign all_eq   = (lvl_q[0] == tgt[0]) && (lvl_q[1] == tgt[1]) && (lvl_q[2] == tgt[2]);

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        btn_d   = mode_btn;
        mode_d  = btn_rise ? mode_e'(~mode_q) : mode_q;
        phase_d = phase_q;
        for (int unsigned i = 0; i < 3; i++) begin
            lvl_d[i] = lvl_q[i];
        end

        // Slew and phase both use the pre-toggle mode. When settled in AUTO the
        // slew is a no-op anyway, so only the phase needs the all_eq gate.
        if (tick) begin
            for (int unsigned i = 0; i < 3; i++) begin
                lvl_d[i] = slew(lvl_q[i], tgt[i]);
            end
            if (mode_q == AUTO && all_eq) begin
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
            end
        end

        // Any mode change restarts the wheel; this overrides a coincident advance.
        if (btn_rise) begin
            phase_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            mode_q  <= MANUAL;
            phase_q <= 3'd0;
            for (int unsigned i = 0; i < 3; i++) begin
                lvl_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            for (int unsigned i = 0; i < 3; i++) begin
                lvl_q[i] <= lvl_d[i];
            end
        end
    end

    assign level0 = lvl_q[0];
    assign level1 = lvl_q[1];
    assign level2 = lvl_q[2];
    assign mode   = mode_q;
    assign phase  = phase_q;
    assign busy   = ~all_eq;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb_rgb_fade_ctrl -- scoreboard bench for rgb_fade_ctrl (LEVEL_WIDTH=8, STEP_CYCLES=4).
// A behavioural model predicts the next register state before each edge and
// queues it. After the edge that prediction is popped and compared to the outputs.
module tb_rgb_fade_ctrl;

    localparam int STEP = 4;
    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] target0 = '0, target1 = '0, target2 = '0;
    logic       mode_btn = 1'b0;
    logic [7:0] level0, level1, level2;
    logic       mode;
    logic [2:0] phase;
    logic       busy;

    rgb_fade_ctrl #(.LEVEL_WIDTH(8), .STEP_CYCLES(STEP)) dut (
        .clk(clk), .reset(reset),
        .target0(target0), .target1(target1), .target2(target2),
        .mode_btn(mode_btn),
        .level0(level0), .level1(level1), .level2(level2),
        .mode(mode), .phase(phase), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l0, l1, l2, md, ph, cnt, btn;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;

    // Model state, mirroring the DUT registers as described by the requirements.
    int m_cnt = 0, m_btn = 0, m_mode = 0, m_phase = 0;
    int m_lvl[3] = '{0, 0, 0};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int eff(input int ch);
        if (m_mode == 0) return (ch == 0) ? int'(target0) : (ch == 1) ? int'(target1) : int'(target2);
        case (ch)
            0: return (m_phase == 0 || m_phase == 4 || m_phase == 5) ? MAXV : 0;
            1: return (m_phase == 0 || m_phase == 1 || m_phase == 2) ? MAXV : 0;
            default: return (m_phase == 2 || m_phase == 3 || m_phase == 4) ? MAXV : 0;
        endcase
    endfunction

    function automatic int step_toward(input int v, input int t);
        return (v < t) ? v + 1 : (v > t) ? v - 1 : v;
    endfunction

    // Predict, clock, then pop and compare.
    task automatic step();
        exp_t e;
        int   lv[3];
        int   tick, rise, settled;
        if (reset) begin
            e = '{0, 0, 0, 0, 0, 0, 0};
        end else begin
            tick    = (m_cnt == STEP - 1);
            rise    = (mode_btn && m_btn == 0);
            settled = (m_lvl[0] == eff(0)) && (m_lvl[1] == eff(1)) && (m_lvl[2] == eff(2));
            for (int i = 0; i < 3; i++) lv[i] = tick ? step_toward(m_lvl[i], eff(i)) : m_lvl[i];
            e.l0 = lv[0]; e.l1 = lv[1]; e.l2 = lv[2];
            e.ph = m_phase;
            if (tick && m_mode == 1 && settled) e.ph = (m_phase + 1) % 6;
            if (rise) e.ph = 0;
            e.md  = rise ? 1 - m_mode : m_mode;
            e.cnt = tick ? 0 : m_cnt + 1;
            e.btn = int'(mode_btn);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        m_lvl[0] = e.l0; m_lvl[1] = e.l1; m_lvl[2] = e.l2;
        m_mode = e.md; m_phase = e.ph; m_cnt = e.cnt; m_btn = e.btn;
        check_eq("level0", int'(level0), e.l0);
        check_eq("level1", int'(level1), e.l1);
        check_eq("level2", int'(level2), e.l2);
        check_eq("mode", int'(mode), e.md);
        check_eq("phase", int'(phase), e.ph);
        check_eq("busy", int'(busy),
                 ((m_lvl[0] != eff(0)) || (m_lvl[1] != eff(1)) || (m_lvl[2] != eff(2))) ? 1 : 0);
    endtask

    task automatic pulse_btn();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    initial begin
        // Reset with all MANUAL targets 0: everything 0, busy 0.
        reset = 1'b1;
        step();
        step();
        check_eq("reset_busy", int'(busy), 0);

        // Ramp level0 to 3, one step on each tick (clocks 4, 8, 12).
        target0 = 8'd3;
        reset   = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i % 4 == 0) check_eq("ramp_l0", int'(level0), i / 4);
        end
        check_eq("ramp_busy", int'(busy), 0);
        check_eq("ramp_l1", int'(level1), 0);

        // Lower target: 3 -> 2 -> 1, then holds at 1.
        target0 = 8'd1;
        for (int i = 0; i < 16; i++) step();
        check_eq("down_l0", int'(level0), 1);

        // Enter AUTO: ramp ch0/ch1 to MAX, then phase 1 and ch0 falls.
        target0 = 8'd0;
        pulse_btn();
        check_eq("auto_mode", int'(mode), 1);
        for (int i = 0; i < 1200 && phase != 3'd1; i++) step();
        check_eq("auto_ph1", int'(phase), 1);
        check_eq("auto_l0max", int'(level0), MAXV);
        check_eq("auto_l1max", int'(level1), MAXV);
        for (int i = 0; i < STEP; i++) step();
        check_eq("auto_l0fall", int'(level0), MAXV - 1);

        // Run the wheel through phase 5 and back to 0.
        for (int i = 0; i < 7000 && phase != 3'd5; i++) step();
        check_eq("wheel_ph5", int'(phase), 5);
        for (int i = 0; i < 1200 && phase != 3'd0; i++) step();
        check_eq("wheel_wrap", int'(phase), 0);
        for (int i = 0; i < 1200 && busy; i++) step();
        check_eq("wheel_l0", int'(level0), MAXV);
        check_eq("wheel_l1", int'(level1), MAXV);
        check_eq("wheel_l2", int'(level2), 0);

        // Button edge in a tick cycle while AUTO; held high 10 cycles toggles once.
        for (int i = 0; i < 2 * STEP && m_cnt != STEP - 1; i++) step();
        mode_btn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        mode_btn = 1'b0;
        step();
        check_eq("exit_mode", int'(mode), 0);
        check_eq("exit_phase", int'(phase), 0);

        // Random MANUAL targets and occasional button presses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                target0 = 8'($urandom_range(0, 255));
                target1 = 8'($urandom_range(0, 255));
                target2 = 8'($urandom_range(0, 255));
            end
            mode_btn = ($urandom_range(0, 40) == 0);
            step();
        end
        mode_btn = 1'b0;

        // Reset mid-ramp at level1 == 100, then restart timing.
        reset = 1'b1;
        step();
        reset = 1'b0;
        pulse_btn();
        for (int i = 0; i < 600 && level1 != 8'd100; i++) step();
        check_eq("mid_l1", int'(level1), 100);
        target0 = 8'd0; target1 = 8'd50; target2 = 8'd0;
        reset = 1'b1;
        step();
        check_eq("rst_l0", int'(level0), 0);
        check_eq("rst_l1", int'(level1), 0);
        check_eq("rst_mode", int'(mode), 0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("rst_restart_l1", int'(level1), (i == 4) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
